// File: rtl/mux_2to1_sel.sv
// mux_2to1_sel: combinational 2-to-1 selector with registered copy and saturating select-toggle counter
module mux_2to1_sel #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Select,
  input  logic [WIDTH-1:0] i_Data1,
  input  logic [WIDTH-1:0] i_Data2,
  input  logic             i_En,
  output logic [WIDTH-1:0] o_Data,
  output logic [WIDTH-1:0] o_Data_R,
  output logic             o_Valid,
  output logic [CNT_W-1:0] o_Toggle_Cnt
);
  logic prev_sel;
  always_comb o_Data = i_Select ? i_Data2 : i_Data1;
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Data_R     <= '0;
      o_Valid      <= 1'b0;
      o_Toggle_Cnt <= '0;
      prev_sel     <= 1'b0;
    end else begin
      prev_sel <= i_Select;
      if (i_En) begin
        o_Data_R <= o_Data;
        o_Valid  <= 1'b1;
      end
      if (i_Select != prev_sel && !(&o_Toggle_Cnt)) o_Toggle_Cnt <= o_Toggle_Cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mux_2to1_sel.sv
// tb_mux_2to1_sel: directed vector bench for a 32-bit instance and a 1-bit, 2-bit-counter instance
module tb_mux_2to1_sel;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, sel, en;
  logic [31:0] d1, d2, data, data_r;
  logic valid;
  logic [15:0] cnt;
  logic s_sel, s_d1, s_d2, s_en, s_data, s_data_r, s_valid;
  logic [1:0] s_cnt;
  int checks = 0, failures = 0;

  mux_2to1_sel #(.WIDTH(32), .CNT_W(16)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Select(sel), .i_Data1(d1), .i_Data2(d2), .i_En(en),
    .o_Data(data), .o_Data_R(data_r), .o_Valid(valid), .o_Toggle_Cnt(cnt)
  );
  mux_2to1_sel #(.WIDTH(1), .CNT_W(2)) dut_s (
    .i_Clk(clk), .i_Reset(rst), .i_Select(s_sel), .i_Data1(s_d1), .i_Data2(s_d2), .i_En(s_en),
    .o_Data(s_data), .o_Data_R(s_data_r), .o_Valid(s_valid), .o_Toggle_Cnt(s_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];
  logic [4:0] tog_seq;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
    vecs[2] = '{1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    rst = 1'b1; sel = 1'b0; en = 1'b0; d1 = '0; d2 = '0;
    s_sel = 1'b0; s_d1 = 1'b0; s_d2 = 1'b0; s_en = 1'b0;
    #2;
    chk("reset_data_r", data_r, 32'h0);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_cnt", {16'h0, cnt}, 32'h0);
    chk("reset_small_cnt", {30'h0, s_cnt}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel; d1 = vecs[i].d1; d2 = vecs[i].d2;
      #1;
      chk($sformatf("comb_vec%0d", i), data, vecs[i].exp);
    end
    s_d1 = 1'b1; s_d2 = 1'b0; s_sel = 1'b0;
    #1 chk("comb1_sel0", {31'h0, s_data}, 32'h1);
    s_sel = 1'b1;
    #1 chk("comb1_sel1", {31'h0, s_data}, 32'h0);
    s_sel = 1'b0; sel = 1'b0;
    @(negedge clk) rst = 1'b0;
    d1 = 32'hDEAD_BEEF; en = 1'b1;
    @(negedge clk) en = 1'b0;
    chk("en_capture", data_r, 32'hDEAD_BEEF);
    chk("en_valid", {31'h0, valid}, 32'h1);
    d1 = 32'h1234_5678;
    @(negedge clk);
    chk("en_hold", data_r, 32'hDEAD_BEEF);
    chk("valid_hold", {31'h0, valid}, 32'h1);
    chk("comb_after_hold", data, 32'h1234_5678);
    chk("cnt_no_toggle", {16'h0, cnt}, 32'h0);
    tog_seq = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      sel = tog_seq[i];
      @(negedge clk);
    end
    chk("toggle_seq_cnt", {16'h0, cnt}, 32'd3);
    en = 1'b1; sel = 1'b0; d1 = 32'hDEAD_BEEF; d2 = 32'hAAAA_5555;
    @(negedge clk) en = 1'b0;
    chk("same_cycle_capture", data_r, 32'hDEAD_BEEF);
    chk("same_cycle_cnt", {16'h0, cnt}, 32'd4);
    sel = 1'b1;
    @(negedge clk);
    chk("cnt_five", {16'h0, cnt}, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_data_r", data_r, 32'h0);
    chk("async_valid", {31'h0, valid}, 32'h0);
    chk("async_cnt", {16'h0, cnt}, 32'h0);
    chk("reset_comb_follow", data, 32'hAAAA_5555);
    d2 = 32'h0F0F_0F0F;
    #1 chk("reset_comb_track", data, 32'h0F0F_0F0F);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("post_reset_toggle", {16'h0, cnt}, 32'd1);
    chk("post_reset_valid", {31'h0, valid}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      s_sel = ~s_sel;
      @(negedge clk);
      chk($sformatf("sat_edge%0d", i), {30'h0, s_cnt}, (i < 2) ? i + 1 : 3);
    end
    s_en = 1'b1; s_sel = 1'b0;
    @(negedge clk) s_en = 1'b0;
    chk("small_capture", {31'h0, s_data_r}, 32'h1);
    chk("small_sat_hold", {30'h0, s_cnt}, 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_2to1_sel.md
# mux_2to1_sel

Parameterised 2-to-1 data selector used throughout the datapath, e.g. for the ALU's signed/unsigned less-than choice (1-bit) and for forming the set-less-than result word (32-bit). It provides a zero-latency combinational output for in-cycle datapath use. It also provides an optional registered copy with enable and a saturating select-toggle counter for pipeline staging and debug.

## Interface
Parameters:
- WIDTH, default 1: data width of both inputs and all data outputs.
- CNT_W, default 16: width of the select-toggle counter.

Ports:
- i_Clk  input  1  clock; all state updates on the rising edge.
- i_Reset  input  1  one clock; reset is asynchronous and active-high; clears all registered state immediately.
- i_Select  input  1  0 selects i_Data1, 1 selects i_Data2.
- i_Data1  input  WIDTH  operand routed when i_Select=0.
- i_Data2  input  WIDTH  operand routed when i_Select=1.
- i_En  input  1  capture enable for the registered output.
- o_Data  output  WIDTH  combinational selection result.
- o_Data_R  output  WIDTH  registered selection result.
- o_Valid  output  1  high once o_Data_R holds a captured value.
- o_Toggle_Cnt  output  CNT_W  saturating count of i_Select transitions.

## Operation
- o_Data = i_Select ? i_Data2 : i_Data1. The path is purely combinational, with no dependence on i_Clk, i_Reset or i_En.
- Only i_Select == 1 selects i_Data2; 0 selects i_Data1. Simulation behaviour for X/Z on i_Select follows the native conditional operator, and no explicit X handling is needed.
- Data bits pass through unmodified. There is no sign or zero extension, and both inputs are exactly WIDTH bits.
- Registered path: on each rising edge with i_En=1, o_Data_R takes the current o_Data value and o_Valid is set to 1. With i_En=0, o_Data_R and o_Valid hold their values.
- Once set, o_Valid stays 1 until reset.
- Toggle counter:
  - An internal register tracks the previous i_Select value; it resets to 0.
  - On each rising edge, if i_Select differs from that register, o_Toggle_Cnt increments by 1.
  - The counter saturates at all-ones and never wraps.
  - The previous-select register updates every cycle, independent of i_En.

## Timing
- o_Data latency: 0 cycles (combinational).
- o_Data_R latency: 1 cycle after the capturing edge.
- While i_Reset is high, o_Data_R = 0, o_Valid = 0, o_Toggle_Cnt = 0 and previous-select = 0, all asserted asynchronously.
- o_Data continues to follow the inputs during reset.
- Reset asserted mid-operation clears the registered state at once, without waiting for a clock edge.
- On the first rising edge after i_Reset deasserts, normal capture and counting resume.
- A select change in the first post-reset cycle to i_Select=1 counts as a toggle, because previous-select resets to 0.
- If i_En=1 and i_Select changes in the same cycle, o_Data_R captures the data selected by the new i_Select value, and the toggle counter increments.
- Counter saturation: at all-ones, further toggles leave o_Toggle_Cnt unchanged.

## Test plan
- Combinational select, WIDTH=1: i_Data1=1, i_Data2=0. With i_Select=0, o_Data=1; with i_Select=1, o_Data=0. Both change with no clock edge.
- WIDTH=32, set-less-than form: i_Data1=32'h0000_0000, i_Data2=32'h0000_0001. i_Select=0 gives o_Data=0x00000000; i_Select=1 gives o_Data=0x00000001.
- Register enable, WIDTH=32: i_Data1=0xDEADBEEF, i_Select=0, i_En=1 for one edge. Then o_Data_R=0xDEADBEEF and o_Valid=1. Next, i_En=0 with i_Data1=0x12345678: o_Data_R stays 0xDEADBEEF.
- Async reset mid-operation: with o_Data_R=0xDEADBEEF and o_Toggle_Cnt=5, pulse i_Reset between clock edges. o_Data_R, o_Valid and o_Toggle_Cnt go to 0 immediately, while o_Data still tracks the inputs.
- Toggle count: after reset, drive i_Select with the sequence 0,1,1,0,1 across 5 edges. o_Toggle_Cnt = 3.
- Saturation with CNT_W=2: toggle i_Select on every edge for 6 edges. o_Toggle_Cnt reaches 3 and holds at 3.
